eb_rr_arb: RTL and testbench

Round-robin arbiter that shares one elastic req/ack sink (typically the write side of an `eb_fifo_ctrl` FIFO) among N requesting streams. It picks one requester per transfer and drives a select index that steers the shared data mux. The grant is held stable while a transfer is stalled. An optional packet-lock feature keeps ownership until a requester signals last.

---
 rtl/eb_arb_pkg.sv | 20 ++
 rtl/eb_rr_pick.sv | 37 +++
 rtl/eb_rr_arb.sv | 162 ++++++++++++++++
 tb/tb_eb_rr_arb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/eb_arb_pkg.sv
// Shared definitions for the elastic-buffer round-robin arbiter.
// Lock states are only used when the build defines EB_ARB_LOCK_EN.
package eb_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } lock_state_t;

    // Ceiling log2, used to cross-check the select width against N.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/eb_rr_pick.sv
// Combinational rotate-priority encoder: scans from ptr upward modulo N
// and grants the first active request.
module eb_rr_pick
    import eb_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] idx,
    output logic            any
);

    // Walk the N candidates starting at ptr; indices >= N are never formed.
    always_comb begin : p_scan
        int cand;
        cand = 0;
        gnt  = {N{1'b0}};
        idx  = {SELW{1'b0}};
        any  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = int'(ptr) + i;
            cand = (cand >= N) ? cand - N : cand;
            cand = (cand >= N) ? cand - N : cand;
            if (!any && req[cand[SELW-1:0]]) begin
                any                   = 1'b1;
                idx                   = cand[SELW-1:0];
                gnt[cand[SELW-1:0]]   = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/eb_rr_arb.sv
// Round-robin arbiter sharing one req/ack sink among N requesters.
// Grant is held through sink stalls. Optional packet locking is enabled
// by defining EB_ARB_LOCK_EN: ownership then persists until t_last.
// The outputs are combinational so a stream sees zero-cycle latency;
// i_0_ack only reaches t_ack, never i_0_req or i_0_sel.
module eb_rr_arb
    import eb_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    t_req,
    output logic [N-1:0]    t_ack,
    input  logic [N-1:0]    t_last,
    output logic            i_0_req,
    input  logic            i_0_ack,
    output logic [SELW-1:0] i_0_sel,
    output logic            i_0_last
);

    if (SELW != clog2(N) || N < 2 || N > 16) begin : g_param_chk
        $error("eb_rr_arb: N must be 2..16 and SELW must equal clog2(N)");
    end

    logic [SELW-1:0] ptr_r;
    logic            hold_vld_r;
    logic [SELW-1:0] hold_idx_r;

    logic [N-1:0]    pick_gnt_s;
    logic [SELW-1:0] pick_idx_s;
    logic            pick_any_s;

    logic [N-1:0]    grant_s;
    logic [SELW-1:0] gidx_s;
    logic            gvld_s;
    logic            xfer_s;
    logic            ptr_upd_s;

`ifdef EB_ARB_LOCK_EN
    lock_state_t     lock_state_r;
    lock_state_t     lock_next_s;
    logic [SELW-1:0] owner_r;
    logic [SELW-1:0] owner_next_s;
`endif

    eb_rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_pick (
        .req (t_req),
        .ptr (ptr_r),
        .gnt (pick_gnt_s),
        .idx (pick_idx_s),
        .any (pick_any_s)
    );

    // Grant selection: lock owner first, then a live hold, else fresh arbitration.
    always_comb begin
        gvld_s  = 1'b0;
        gidx_s  = {SELW{1'b0}};
        grant_s = {N{1'b0}};
`ifdef EB_ARB_LOCK_EN
        if (lock_state_r == ARB_LOCKED) begin
            if (t_req[owner_r]) begin
                gvld_s  = 1'b1;
                gidx_s  = owner_r;
                grant_s = N'(1'b1) << owner_r;
            end else begin
                gvld_s  = 1'b0;
            end
        end else
`endif
        if (hold_vld_r && t_req[hold_idx_r]) begin
            gvld_s  = 1'b1;
            gidx_s  = hold_idx_r;
            grant_s = N'(1'b1) << hold_idx_r;
        end else begin
            gvld_s  = pick_any_s;
            gidx_s  = pick_idx_s;
            grant_s = pick_gnt_s;
        end
    end

    // Output muxing and transfer detection.
    always_comb begin
        i_0_req  = gvld_s;
        i_0_sel  = gidx_s;
        t_ack    = i_0_ack ? grant_s : {N{1'b0}};
        i_0_last = |(t_last & grant_s);
        xfer_s   = gvld_s && i_0_ack;
`ifdef EB_ARB_LOCK_EN
        ptr_upd_s = xfer_s && i_0_last;
`else
        ptr_upd_s = xfer_s;
`endif
    end

    // Priority pointer advances past the winner; hold tracks a stalled grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r      <= {SELW{1'b0}};
            hold_vld_r <= 1'b0;
            hold_idx_r <= {SELW{1'b0}};
        end else begin
            if (ptr_upd_s) begin
                ptr_r <= (gidx_s == SELW'(N-1)) ? {SELW{1'b0}} : gidx_s + SELW'(1'b1);
            end else begin
                ptr_r <= ptr_r;
            end
            if (xfer_s) begin
                hold_vld_r <= 1'b0;
            end else if (gvld_s) begin
                hold_vld_r <= 1'b1;
                hold_idx_r <= gidx_s;
            end else begin
                hold_vld_r <= 1'b0;
            end
        end
    end

`ifdef EB_ARB_LOCK_EN
    // Lock FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_state_r <= ARB_IDLE;
            owner_r      <= {SELW{1'b0}};
        end else begin
            lock_state_r <= lock_next_s;
            owner_r      <= owner_next_s;
        end
    end

    // Lock FSM next state: lock on a non-last beat, release on the owner's last beat.
    always_comb begin
        lock_next_s  = lock_state_r;
        owner_next_s = owner_r;
        case (lock_state_r)
            ARB_IDLE: begin
                if (xfer_s && !i_0_last) begin
                    lock_next_s  = ARB_LOCKED;
                    owner_next_s = gidx_s;
                end else begin
                    lock_next_s  = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (xfer_s && i_0_last) begin
                    lock_next_s = ARB_IDLE;
                end else begin
                    lock_next_s = ARB_LOCKED;
                end
            end
            default: begin
                lock_next_s = ARB_IDLE;
            end
        endcase
    end
`endif

endmodule

// File: tb/tb_eb_rr_arb.sv
// Self-checking bench for eb_rr_arb (N=4 and N=3 instances). Directed
// table vectors, hand sequences for stall/lock/reset, then randomized
// traffic against a behavioural model. Honors EB_ARB_LOCK_EN.
module tb_eb_rr_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] t_req, t_ack, t_last;
    logic       i_0_req, i_0_ack, i_0_last;
    logic [1:0] i_0_sel;

    logic [2:0] t_req3, t_ack3, t_last3;
    logic       req3, ack3, last3;
    logic [1:0] sel3;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [3:0] req;
        logic       ack;
        logic       e_req;
        logic [1:0] e_sel;
        logic [3:0] e_ack;
        logic       e_last;
    } vec_t;

    vec_t tbl[$];

    // Behavioural model state: -1 means none.
    int m_ptr, m_hold, m_owner;

    eb_rr_arb #(.N(4), .SELW(2)) dut (
        .clk(clk), .reset_n(reset_n), .t_req(t_req), .t_ack(t_ack), .t_last(t_last),
        .i_0_req(i_0_req), .i_0_ack(i_0_ack), .i_0_sel(i_0_sel), .i_0_last(i_0_last)
    );

    eb_rr_arb #(.N(3), .SELW(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .t_req(t_req3), .t_ack(t_ack3), .t_last(t_last3),
        .i_0_req(req3), .i_0_ack(ack3), .i_0_sel(sel3), .i_0_last(last3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic add(input logic [3:0] req, input logic ack, input logic e_req,
                       input logic [1:0] e_sel, input logic [3:0] e_ack, input logic e_last);
        vec_t v;
        v = '{req, ack, e_req, e_sel, e_ack, e_last};
        tbl.push_back(v);
    endtask

    // Drive one cycle (called at posedge+1), check outputs mid-cycle, advance.
    task automatic step(input string name, input logic [3:0] req, input logic [3:0] last,
                        input logic ack, input logic e_req, input logic [1:0] e_sel,
                        input logic [3:0] e_ack, input logic e_last);
        t_req = req; t_last = last; i_0_ack = ack;
        #2;
        chk({name, ".req"},  {7'd0, i_0_req},  {7'd0, e_req});
        chk({name, ".sel"},  {6'd0, i_0_sel},  {6'd0, e_sel});
        chk({name, ".ack"},  {4'd0, t_ack},    {4'd0, e_ack});
        chk({name, ".last"}, {7'd0, i_0_last}, {7'd0, e_last});
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    // Spec rule: locked owner only; else live hold; else first request from ptr.
    function automatic int ref_grant(input logic [3:0] req);
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        if (m_hold >= 0 && req[m_hold]) return m_hold;
        for (int i = 0; i < 4; i++) begin
            if (req[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic ref_update(input int g, input logic [3:0] last, input logic ack);
        if (g >= 0 && ack) begin
            m_hold = -1;
`ifdef EB_ARB_LOCK_EN
            if (last[g]) begin
                m_owner = -1;
                m_ptr   = (g + 1) % 4;
            end else begin
                m_owner = g;
            end
`else
            m_ptr = (g + 1) % 4;
`endif
        end else if (g >= 0) begin
            m_hold = g;
        end else begin
            m_hold = -1;
        end
    endtask

    initial begin
        logic [3:0] rq, rl, ea;
        logic       ra;
        int         g;

        t_req = 4'd0; t_last = 4'b1111; i_0_ack = 1'b0;
        t_req3 = 3'd0; t_last3 = 3'b111; ack3 = 1'b0;
        reset_n = 1'b0;
        #2;
        chk("rst.req", {7'd0, i_0_req}, 8'd0);
        chk("rst.sel", {6'd0, i_0_sel}, 8'd0);
        chk("rst.ack", {4'd0, t_ack},   8'd0);
        chk("rst.last", {7'd0, i_0_last}, 8'd0);
        do_reset();

        // Directed table: round-robin, stall hold, idle, sparse wrap.
        for (int i = 0; i < 8; i++) add(4'b1111, 1'b1, 1'b1, 2'(i % 4), 4'(1 << (i % 4)), 1'b1);
        for (int i = 0; i < 3; i++) add(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0000, 1'b1);
        add(4'b0110, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);
        add(4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        add(4'b0000, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        add(4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        add(4'b1001, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b1);
        add(4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].req, 4'b1111, tbl[i].ack,
                 tbl[i].e_req, tbl[i].e_sel, tbl[i].e_ack, tbl[i].e_last);
        end

        // Packet sequence from requester 2 while requester 0 waits (ptr is 1 here).
`ifdef EB_ARB_LOCK_EN
        step("lock.b0",   4'b0101, 4'b1011, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        step("lock.gap",  4'b0001, 4'b1011, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0);
        step("lock.b1",   4'b0101, 4'b1011, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        step("lock.b2",   4'b0101, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        step("lock.next", 4'b0101, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
`else
        step("nolock.b0",   4'b0101, 4'b1011, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        step("nolock.next", 4'b0101, 4'b1011, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
`endif

        // Reset during a stall on index 3 drops the hold immediately.
        step("rs.stall0", 4'b1000, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b1);
        step("rs.stall1", 4'b1000, 4'b1111, 1'b0, 1'b1, 2'd3, 4'b0000, 1'b1);
        t_req = 4'b1111; i_0_ack = 1'b0; reset_n = 1'b0;
        #2;
        chk("rs.in.ack", {4'd0, t_ack}, 8'd0);
        chk("rs.in.sel", {6'd0, i_0_sel}, 8'd0);
        t_req = 4'b0000;
        #1;
        chk("rs.idle.req", {7'd0, i_0_req}, 8'd0);
        chk("rs.idle.sel", {6'd0, i_0_sel}, 8'd0);
        chk("rs.idle.ack", {4'd0, t_ack}, 8'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        step("rs.after0", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        step("rs.after1", 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b1);

        // N=3 wrap on the second instance (its pointer is at 0 after the reset).
        t_req = 4'd0;
        t_req3 = 3'b111; ack3 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            chk($sformatf("n3.sel%0d", i), {6'd0, sel3}, 8'(i % 3));
            chk($sformatf("n3.ack%0d", i), {5'd0, t_ack3}, 8'(1 << (i % 3)));
            @(posedge clk); #1;
        end
        t_req3 = 3'b000;
        #2;
        chk("n3.idle.req", {7'd0, req3}, 8'd0);
        chk("n3.idle.sel", {6'd0, sel3}, 8'd0);
        @(posedge clk); #1;

        // Randomized traffic against the behavioural model.
        do_reset();
        m_ptr = 0; m_hold = -1; m_owner = -1;
        rq = 4'd0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 0) rq = 4'($urandom_range(0, 15));
            rl = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) != 0);
            g  = ref_grant(rq);
            t_req = rq; t_last = rl; i_0_ack = ra;
            #2;
            ea = (g >= 0 && ra) ? 4'(1 << g) : 4'd0;
            chk($sformatf("rnd%0d.req", c), {7'd0, i_0_req}, (g >= 0) ? 8'd1 : 8'd0);
            chk($sformatf("rnd%0d.sel", c), {6'd0, i_0_sel}, (g >= 0) ? 8'(g) : 8'd0);
            chk($sformatf("rnd%0d.ack", c), {4'd0, t_ack}, {4'd0, ea});
            chk($sformatf("rnd%0d.last", c), {7'd0, i_0_last}, (g >= 0) ? {7'd0, rl[g]} : 8'd0);
            ref_update(g, rl, ra);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
